// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer followed by a counter-qualified stability FSM.
// Define DEBOUNCE_ACTIVE_LOW_EN to treat btn_in as an active-low (idle-high) pin.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic enb,
   input  logic btn_in,
   output logic btn_clean,
   output logic busy
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW,
      WAIT_HIGH,
      HIGH,
      WAIT_LOW
   } state_t;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
   localparam logic SYNC_IDLE = 1'b1;
`else
   localparam logic SYNC_IDLE = 1'b0;
`endif

   logic             sync_ff1;
   logic             sync_ff2;
   logic             btn_sync;
   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             btn_clean_next;
   logic             busy_next;

   // Synchronizer runs every cycle; the enable only gates the filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff1 <= SYNC_IDLE;
         sync_ff2 <= SYNC_IDLE;
      end else begin
         sync_ff1 <= btn_in;
         sync_ff2 <= sync_ff1;
      end
   end

`ifdef DEBOUNCE_ACTIVE_LOW_EN
   assign btn_sync = ~sync_ff2;
`else
   assign btn_sync = sync_ff2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= LOW;
         cnt_reg   <= '0;
         btn_clean <= 1'b0;
         busy      <= 1'b0;
      end else if (enb) begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         btn_clean <= btn_clean_next;
         busy      <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         LOW: begin
            if (btn_sync) begin
               state_next = WAIT_HIGH;
               cnt_next   = '0;
            end
         end
         WAIT_HIGH: begin
            // A reverting input wins over a simultaneous terminal count.
            if (!btn_sync) begin
               state_next = LOW;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!btn_sync) begin
               state_next = WAIT_LOW;
               cnt_next   = '0;
            end
         end
         WAIT_LOW: begin
            if (btn_sync) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      btn_clean_next = (state_next == HIGH) || (state_next == WAIT_LOW);
      busy_next      = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4: vector table plus
// hand-written sequences for stall, reset-during-qualification and bounce-at-terminal-count.
module tb_button_debouncer;

   typedef struct {
      logic rst;
      logic enb;
      logic btn;
      logic exp_clean;
      logic exp_busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enb = 1'b1;
   logic btn_in = 1'b0;
   logic btn_clean;
   logic busy;

   int applied = 0;
   int miscompares = 0;

   vec_t vecs[$];

   button_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enb       (enb),
      .btn_in    (btn_in),
      .btn_clean (btn_clean),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic e, input logic b,
                      input logic c, input logic y);
      vec_t v;
      v.rst = r; v.enb = e; v.btn = b; v.exp_clean = c; v.exp_busy = y;
      vecs.push_back(v);
   endtask

   // Drive inputs, take one clock edge, sample #1 after it and compare.
   task automatic step(input string name, input logic r, input logic e, input logic b,
                       input logic c, input logic y);
      rst = r; enb = e; btn_in = b;
      @(posedge clk);
      #1;
      applied++;
      if (btn_clean !== c || busy !== y) begin
         miscompares++;
         $display("FAIL %s #%0d: got clean=%b busy=%b, want clean=%b busy=%b",
                  name, applied, btn_clean, busy, c, y);
      end else begin
         $display("ok   %s #%0d: rst=%b enb=%b btn=%b -> clean=%b busy=%b",
                  name, applied, r, e, b, btn_clean, busy);
      end
   endtask

   initial begin
      // Reset, then idle low for 20 cycles.
      add(1, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) add(0, 1, 0, 0, 0);
      // Clean press: busy after edges 3..6, btn_clean after edge 7.
      add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0);
      add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1);
      add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0);
      // Clean release.
      add(0, 1, 0, 1, 0); add(0, 1, 0, 1, 0);
      add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1);
      add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);
      // 3-cycle bounce is rejected.
      add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);
      // Press to HIGH, then release bounce of 2 cycles, then final release.
      add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0);
      add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1); add(0, 1, 1, 0, 1);
      add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0);
      add(0, 1, 0, 1, 0); add(0, 1, 0, 1, 0);
      add(0, 1, 1, 1, 1); add(0, 1, 1, 1, 1);
      add(0, 1, 0, 1, 0); add(0, 1, 0, 1, 0);
      add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1); add(0, 1, 0, 1, 1);
      add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);

      foreach (vecs[i])
         step("table", vecs[i].rst, vecs[i].enb, vecs[i].btn,
              vecs[i].exp_clean, vecs[i].exp_busy);

      // Enable stall of 5 cycles mid-WAIT_HIGH delays btn_clean by 5 cycles.
      step("stall", 0, 1, 1, 0, 0);
      step("stall", 0, 1, 1, 0, 0);
      step("stall", 0, 1, 1, 0, 1);
      step("stall", 0, 1, 1, 0, 1);
      for (int i = 0; i < 5; i++) step("stall_hold", 0, 0, 1, 0, 1);
      step("stall", 0, 1, 1, 0, 1);
      step("stall", 0, 1, 1, 0, 1);
      step("stall_rise", 0, 1, 1, 1, 0);
      step("stall_release", 0, 1, 0, 1, 0);
      step("stall_release", 0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step("stall_release", 0, 1, 0, 1, 1);
      step("stall_release", 0, 1, 0, 0, 0);
      step("stall_release", 0, 1, 0, 0, 0);

      // Reset during WAIT_HIGH with button held: requalify from scratch.
      step("rst_mid", 0, 1, 1, 0, 0);
      step("rst_mid", 0, 1, 1, 0, 0);
      step("rst_mid", 0, 1, 1, 0, 1);
      step("rst_mid", 0, 1, 1, 0, 1);
      step("rst_pulse", 1, 1, 1, 0, 0);
      step("requal", 0, 1, 1, 0, 0);
      step("requal", 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step("requal", 0, 1, 1, 0, 1);
      step("requal_rise", 0, 1, 1, 1, 0);
      step("requal_release", 0, 1, 0, 1, 0);
      step("requal_release", 0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step("requal_release", 0, 1, 0, 1, 1);
      step("requal_release", 0, 1, 0, 0, 0);

      // Input reverts on the same edge the count reaches its terminal value.
      for (int i = 0; i < 2; i++) step("bounce_tc", 0, 1, 1, 0, 0);
      for (int i = 0; i < 2; i++) step("bounce_tc", 0, 1, 1, 0, 1);
      step("bounce_tc", 0, 1, 0, 0, 1);
      step("bounce_tc", 0, 1, 0, 0, 1);
      step("bounce_tc_reject", 0, 1, 0, 0, 0);
      step("bounce_tc_reject", 0, 1, 0, 0, 0);
      step("bounce_tc_reject", 0, 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw asynchronous start push-button into a clean, glitch-free level.
- Sits directly upstream of the rising-edge one-shot that launches the MDR (multiply/divide/root) operation; btn_clean drives the one-shot's Data_Input.
- Chain: 2-FF synchronizer, then a counter-based stability filter FSM.
- Output changes only after the synchronized input has held a new value for DEBOUNCE_CYCLES consecutive enabled cycles.

Parameters:
- DEBOUNCE_CYCLES, 500000, required stable enabled cycles before btn_clean changes (10 ms at 50 MHz); legal range >= 1.
- CNT_W, localparam = max(1, $clog2(DEBOUNCE_CYCLES)), counter width; not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enb  input  1  clock enable for FSM and counter.
- btn_in  input  1  raw asynchronous push-button level, active-high.
- btn_clean  output  1  debounced level; registered.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync_ff1 = sync_ff2 = 0.
  - state = LOW, cnt = 0.
  - btn_clean = 0, busy = 0.
  - rst has priority over enb.
- Synchronizer:
  - Always samples, independent of enb.
  - btn_sync = sync_ff2, giving 2 cycles of latency from btn_in.
- FSM and counter advance only on edges where enb=1. With enb=0, state, cnt and outputs hold.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
- LOW:
  - btn_sync=1: go to WAIT_HIGH, cnt=0.
  - Otherwise stay in LOW.
- WAIT_HIGH:
  - btn_sync=0: go to LOW, cnt=0 (bounce rejected).
  - Else if cnt==DEBOUNCE_CYCLES-1: go to HIGH, cnt=0.
  - Else cnt=cnt+1.
- HIGH:
  - btn_sync=0: go to WAIT_LOW, cnt=0.
- WAIT_LOW: mirror of WAIT_HIGH.
  - btn_sync=1: go to HIGH.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to LOW.
  - Else cnt=cnt+1.
- Outputs:
  - btn_clean = 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH; registered together with state.
  - busy = 1 in WAIT_HIGH and WAIT_LOW only.
- Latency, enb tied high: btn_clean changes exactly DEBOUNCE_CYCLES+3 edges after btn_in settles.
  - 2 edges synchronizer.
  - 1 edge entering WAIT_*.
  - DEBOUNCE_CYCLES edges qualifying.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
  - Cleared on every state entry.
- DEBOUNCE_CYCLES=1: WAIT_* lasts exactly one enabled cycle.
- Simultaneous bounce and terminal count: btn_sync reverting takes priority; no output change.
- Reset mid-qualification: immediate return to LOW with btn_clean=0. A held button must then requalify from scratch.
- btn_clean produces no edge except a qualified one, so the downstream one-shot receives exactly one rising edge per press.

Optional Feature:
- Macro: DEBOUNCE_ACTIVE_LOW_EN.
- Defined:
  - btn_in is treated as active-low.
  - sync_ff1 and sync_ff2 reset to 1.
  - btn_sync = ~sync_ff2.
  - btn_clean and busy keep active-high meaning; an idle-high pin gives no spurious press after reset.
- Undefined: behaviour exactly as above.

Test Plan (DEBOUNCE_CYCLES=4, enb=1 unless stated):
- Reset then btn_in=0 for 20 cycles -> btn_clean=0, busy=0 throughout.
- btn_in 0->1 held -> busy=1 from edge 3 to edge 6; btn_clean=1 after edge 7; busy=0 after edge 7.
- btn_in pulses 1 for 3 cycles then 0 (bounce) -> busy rises then falls; btn_clean stays 0; FSM back in LOW.
- btn_clean=1, then btn_in drops to 0 and reverts to 1 after 2 cycles, then drops and stays 0 -> btn_clean holds 1 until 7 edges after the final drop, then 0.
- Hold btn_in=1 and assert enb=0 for 5 cycles mid-WAIT_HIGH -> qualification pauses; btn_clean rises 5 cycles later than without the stall.
- rst=1 for 1 cycle during WAIT_HIGH with btn_in held 1 -> next cycle btn_clean=0, busy=0; btn_clean=1 again 7 edges after rst deasserts.
